// File: rtl/traffic_arbiter.sv
// traffic_arbiter
//   Grants one of five traffic signals (Mid, L, R, T, D) access to a shared
//   TrafficSystem. Emergency levels outrank everything; otherwise the highest
//   priority requester wins, with round-robin tie breaking. Every grant is
//   followed by one all-red CLEAR cycle.
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req[4:0]     per-signal request (0 Mid, 1 L, 2 R, 3 T, 4 D)
//   prio[19:0]   4-bit priority per signal, signal i at [4i+3:4i]
//   emer[19:0]   4-bit emergency level per signal, nonzero = emergency
//   act[4:0]     one-hot grant, zero when nothing is granted
//   grant_id     granted index, 7 when act is zero
//   emer_active  current grant is an emergency grant
//   busy         FSM is not in IDLE
module traffic_arbiter #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int EMER_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  req,
  input  logic [19:0] prio,
  input  logic [19:0] emer,
  output logic [4:0]  act,
  output logic [2:0]  grant_id,
  output logic        emer_active,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ARB, HOLD, CLEAR} state_e;

  state_e      state_q, state_d;
  logic [4:0]  act_q, act_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic        emer_active_q, emer_active_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  elapsed_q, elapsed_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;

  // selection results
  logic        emer_any;
  logic [3:0]  e_best;
  logic [2:0]  e_win;
  logic        n_found;
  logic [3:0]  n_best;
  logic [2:0]  n_win;
  logic [2:0]  n_idx;
  logic [2:0]  win_id;
  logic [6:0]  norm_sum;
  logic [5:0]  norm_len;
  logic        req_held;
  logic        release_now;

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // Candidate selection. Emergency: strict '>' scanning upward keeps the
  // lowest index on ties. Normal: scanning from rr_ptr with strict '>' gives
  // the first tied index at or after rr_ptr.
  always_comb begin
    emer_any = |emer;
    e_best   = '0;
    e_win    = '0;
    for (int i = 0; i < 5; i++) begin
      if (emer[4*i +: 4] > e_best) begin
        e_best = emer[4*i +: 4];
        e_win  = 3'(i);
      end
    end
    n_found = 1'b0;
    n_best  = '0;
    n_win   = '0;
    n_idx   = '0;
    for (int k = 0; k < 5; k++) begin
      n_idx = wrap5({1'b0, rr_ptr_q} + 4'(k));
      if (req[n_idx] && (!n_found || prio[4*int'(n_idx) +: 4] > n_best)) begin
        n_found = 1'b1;
        n_best  = prio[4*int'(n_idx) +: 4];
        n_win   = n_idx;
      end
    end
    win_id   = emer_any ? e_win : n_win;
    norm_sum = 7'(GREEN_MIN) + {2'b00, n_best, 1'b0};
    norm_len = (norm_sum > 7'(GREEN_MAX)) ? 6'(GREEN_MAX) : norm_sum[5:0];
  end

  // Held grant's request bit, read through act so grant_id=7 never indexes.
  assign req_held = |(req & act_q);

  // Normal grants end early on preemption or on a post-minimum release.
  assign release_now = !emer_active_q &&
                       (emer_any || (!req_held && elapsed_q >= 6'(GREEN_MIN)));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req || emer_any) state_d = ARB;
      ARB:     state_d = (emer_any || n_found) ? HOLD : IDLE;
      HOLD:    if (cnt_q == 6'd1 || release_now) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant / counter datapath
  always_comb begin
    act_d         = act_q;
    grant_id_d    = grant_id_q;
    emer_active_d = emer_active_q;
    cnt_d         = cnt_q;
    elapsed_d     = elapsed_q;
    rr_ptr_d      = rr_ptr_q;
    case (state_q)
      ARB: begin
        if (emer_any || n_found) begin
          act_d         = 5'd1 << win_id;
          grant_id_d    = win_id;
          emer_active_d = emer_any;
          cnt_d         = emer_any ? 6'(EMER_HOLD) : norm_len;
          elapsed_d     = 6'd1;
          if (!emer_any) rr_ptr_d = wrap5({1'b0, n_win} + 4'd1);
        end
      end
      HOLD: begin
        if (state_d == CLEAR) begin
          act_d         = '0;
          grant_id_d    = 3'd7;
          emer_active_d = 1'b0;
          cnt_d         = '0;
          elapsed_d     = '0;
        end else begin
          cnt_d     = cnt_q - 6'd1;
          elapsed_d = elapsed_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q         <= '0;
      grant_id_q    <= 3'd7;
      emer_active_q <= 1'b0;
      cnt_q         <= '0;
      elapsed_q     <= '0;
      rr_ptr_q      <= '0;
    end else begin
      act_q         <= act_d;
      grant_id_q    <= grant_id_d;
      emer_active_q <= emer_active_d;
      cnt_q         <= cnt_d;
      elapsed_q     <= elapsed_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  // Outputs
  always_comb begin
    act         = act_q;
    grant_id    = grant_id_q;
    emer_active = emer_active_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_traffic_arbiter.sv
module tb_traffic_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req;
  logic [19:0] prio;
  logic [19:0] emer;
  logic [4:0]  act;
  logic [2:0]  grant_id;
  logic        emer_active;
  logic        busy;

  int tests = 0;
  int fails = 0;

  traffic_arbiter #(.GREEN_MIN(8), .GREEN_MAX(32), .EMER_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .prio(prio), .emer(emer),
    .act(act), .grant_id(grant_id), .emer_active(emer_active), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until act is nonzero; k = cycles advanced.
  task automatic wait_act(input string tag, output int k);
    k = 0;
    while (act == 5'd0 && k < 30) begin
      cyc();
      k++;
    end
    check(tag, int'(act != 5'd0), 1);
  endtask

  // Count cycles act stays high, starting from the current (high) cycle.
  task automatic hold_len(output int n);
    n = 0;
    while (act != 5'd0 && n < 100) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    int k;
    int n;
    rst_n = 1'b0; req = '0; prio = '0; emer = '0;
    cyc(); cyc();
    check("rst_act", act, 0);
    check("rst_gid", grant_id, 7);
    check("rst_emer", emer_active, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc();
    check("idle_busy", busy, 0);

    // single requester L, prio 3 -> 14 cycles
    req = 5'b00010; prio = 20'h00030;
    cyc();
    check("arb_busy", busy, 1);
    check("arb_act", act, 0);
    cyc();
    check("single_act", act, 2);
    check("single_gid", grant_id, 1);
    hold_len(n);
    check("single_len", n, 14);
    check("clear_gid", grant_id, 7);
    check("clear_busy", busy, 1);
    req = '0;
    cyc();
    check("idle_after", busy, 0);

    // round-robin tie from reset
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    req = 5'b11111; prio = '0;
    for (int g = 0; g < 6; g++) begin
      wait_act("rr_wait", k);
      if (g > 0) check("rr_gap", k, 3);
      check("rr_gid", grant_id, g % 5);
      check("rr_emer", emer_active, 0);
      hold_len(n);
      check("rr_len", n, 8);
    end
    req = '0;
    cyc();

    // priority: L=2, R=9 -> R for 26 cycles
    req = 5'b00110; prio = 20'h00920;
    wait_act("prio_wait", k);
    check("prio_gid", grant_id, 2);
    check("prio_act", act, 4);
    hold_len(n);
    check("prio_len", n, 26);
    req = '0;
    cyc();

    // candidate disappears during ARB
    req = 5'b00001;
    cyc();
    req = '0;
    cyc();
    check("nocand_busy", busy, 0);
    check("nocand_act", act, 0);

    // preemption of a Mid grant at HOLD cycle 3
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    req = 5'b00001; prio = '0;
    wait_act("pre_wait", k);
    check("pre_gid", grant_id, 0);
    cyc(); cyc();
    emer = 20'h20000; req = '0;
    cyc();
    check("pre_clear_act", act, 0);
    check("pre_clear_gid", grant_id, 7);
    wait_act("emer_wait", k);
    check("emer_gap", k, 3);
    check("emer_act", act, 16);
    check("emer_gid", grant_id, 4);
    check("emer_flag", emer_active, 1);
    // higher emergency elsewhere must not preempt
    emer = 20'h200F0;
    hold_len(n);
    check("emer_len", n, 16);
    check("emer_clr_flag", emer_active, 0);
    emer = '0; req = 5'b11111;
    wait_act("rrkeep_wait", k);
    check("rr_keep_gid", grant_id, 1);
    hold_len(n);
    req = '0;
    cyc();

    // emergency tie -> lowest index
    emer = 20'h03030;
    wait_act("etie_wait", k);
    check("emer_tie_gid", grant_id, 1);
    emer = '0;
    hold_len(n);
    check("emer_tie_len", n, 16);
    cyc();

    // early release at elapsed cycle 10 (loaded 18)
    req = 5'b00001; prio = 20'h00005;
    wait_act("er_wait", k);
    repeat (9) cyc();
    check("er_still", act, 1);
    req = '0;
    cyc();
    check("er_clear_act", act, 0);
    check("er_clear_busy", busy, 1);
    cyc();

    // drop before GREEN_MIN: grant still lasts GREEN_MIN
    req = 5'b00001;
    wait_act("emin_wait", k);
    req = '0;
    hold_len(n);
    check("early_min_len", n, 8);
    cyc();

    // reset mid-HOLD
    req = 5'b00001;
    wait_act("rh_wait", k);
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    check("rh_act", act, 0);
    check("rh_gid", grant_id, 7);
    check("rh_busy", busy, 0);
    rst_n = 1'b1; req = '0;
    cyc();
    check("rh_idle", busy, 0);
    check("rh_idle_act", act, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
